// File: rtl/arm7tdmi_shift_pipe.sv
// ARM7TDMI operand-2 barrel shifter, STAGES deep, valid/ready on both sides.
// Define ARM7TDMI_SHIFT_REGCYCLE_EN to add the extra issue cycle for register-specified shifts.

package arm7tdmi_shift_pkg;
    typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} shift_type_t;
endpackage

module arm7tdmi_shift_pipe
    import arm7tdmi_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  shift_type_t       shift_type,
    input  logic [AMT_W-1:0]  shift_amount,
    input  logic              reg_mode,
    input  logic              carry_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              carry_out,
    output logic [TAG_W-1:0]  tag_out
);

    localparam int LW = $clog2(DATA_W);
    localparam int CW = LW + 1;
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(DATA_W);

    // Every ARM shift collapses to one of these with an amount in 0..DATA_W
    typedef enum logic [2:0] {K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_RRX, K_ZERO} kind_t;

    typedef struct packed {
        kind_t              kind;
        logic [CW-1:0]      amt;
        logic [DATA_W-1:0]  data;
        logic               cin;
        logic [TAG_W-1:0]   tag;
    } op_t;

    logic              adv;
    logic              accept;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;
    logic [AMT_W-1:0]  n;
    op_t               norm;
    op_t               last;
    logic [DATA_W:0]   wl;
    logic [DATA_W:0]   wr;
    logic [DATA_W:0]   wa;
    logic [DATA_W-1:0] rot;
    logic [DATA_W-1:0] res_d;
    logic              res_c;

    assign adv       = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign vld_pipe  = {vld_q, accept};
    assign out_valid = vld_q[STAGES];

`ifdef ARM7TDMI_SHIFT_REGCYCLE_EN
    typedef enum logic {IDLE, REG_WAIT} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = adv;
        case (state)
            IDLE: begin
                if (in_valid && reg_mode && adv) begin
                    in_ready  = 1'b0;
                    state_nxt = REG_WAIT;
                end
            end
            REG_WAIT: begin
                if (!in_valid || adv) state_nxt = IDLE;
            end
        endcase
        if (flush) state_nxt = IDLE;
    end
`else
    assign in_ready = adv;
`endif

    // Stage 1: fold immediate #0 encodings and out-of-range register amounts
    always_comb begin
        n         = reg_mode ? shift_amount : AMT_W'(shift_amount[LW-1:0]);
        norm.kind = K_PASS;
        norm.amt  = '0;
        norm.data = data_in;
        norm.cin  = carry_in;
        norm.tag  = tag_in;
        if (n == '0) begin
            if (!reg_mode) begin
                case (shift_type)
                    SH_LSR:  begin norm.kind = K_LSR; norm.amt = CW'(DATA_W); end
                    SH_ASR:  begin norm.kind = K_ASR; norm.amt = CW'(DATA_W); end
                    SH_ROR:  norm.kind = K_RRX;
                    default: norm.kind = K_PASS;
                endcase
            end
        end else begin
            case (shift_type)
                SH_LSL: begin
                    if (n > W_AMT) norm.kind = K_ZERO;
                    else begin norm.kind = K_LSL; norm.amt = CW'(n); end
                end
                SH_LSR: begin
                    if (n > W_AMT) norm.kind = K_ZERO;
                    else begin norm.kind = K_LSR; norm.amt = CW'(n); end
                end
                SH_ASR: begin
                    norm.kind = K_ASR;
                    norm.amt  = (n >= W_AMT) ? CW'(DATA_W) : CW'(n);
                end
                default: begin
                    norm.kind = K_ROR;
                    norm.amt  = CW'(n[LW-1:0]);
                end
            endcase
        end
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign last = norm;
        end else begin : g_pipe
            op_t pipe_q [STAGES-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < STAGES-1; k++) pipe_q[k] <= '0;
                end else if (adv) begin
                    pipe_q[0] <= norm;
                    for (int k = 1; k < STAGES-1; k++) pipe_q[k] <= pipe_q[k-1];
                end
            end
            assign last = pipe_q[STAGES-2];
        end
    endgenerate

    // One extra guard bit on each side makes the carry fall out of the shift itself
    always_comb begin
        wl    = {1'b0, last.data} << last.amt;
        wr    = {last.data, 1'b0} >> last.amt;
        wa    = $signed({last.data, 1'b0}) >>> last.amt;
        rot   = DATA_W'({last.data, last.data} >> last.amt);
        res_d = last.data;
        res_c = last.cin;
        case (last.kind)
            K_LSL:   begin res_d = wl[DATA_W-1:0]; res_c = wl[DATA_W]; end
            K_LSR:   begin res_d = wr[DATA_W:1];   res_c = wr[0];      end
            K_ASR:   begin res_d = wa[DATA_W:1];   res_c = wa[0];      end
            K_ROR:   begin res_d = rot;            res_c = rot[DATA_W-1]; end
            K_RRX:   begin res_d = {last.cin, last.data[DATA_W-1:1]}; res_c = last.data[0]; end
            K_ZERO:  begin res_d = '0;             res_c = 1'b0;       end
            default: begin res_d = last.data;      res_c = last.cin;   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            data_out  <= '0;
            carry_out <= 1'b0;
            tag_out   <= '0;
        end else begin
            if (adv) begin
                data_out  <= res_d;
                carry_out <= res_c;
                tag_out   <= last.tag;
            end
            if (flush)    vld_q <= '0;
            else if (adv) vld_q <= vld_pipe[STAGES-1:0];
        end
    end

endmodule

// File: tb/tb_arm7tdmi_shift_pipe.sv
// Directed plus random bench for arm7tdmi_shift_pipe against an arithmetic ARM shift model.
module tb_arm7tdmi_shift_pipe;
    import arm7tdmi_shift_pkg::*;

    localparam int W  = 32;
    localparam int AW = 8;
    localparam int ST = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, reg_mode, carry_in;
    logic          out_valid, out_ready, carry_out;
    logic [W-1:0]  data_in, data_out;
    logic [AW-1:0] shift_amount;
    logic [TW-1:0] tag_in, tag_out;
    shift_type_t   shift_type;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic          c;
        logic [TW-1:0] tg;
    } exp_t;
    exp_t q[$];

    arm7tdmi_shift_pipe #(.DATA_W(W), .AMT_W(AW), .STAGES(ST), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_type(shift_type), .shift_amount(shift_amount),
        .reg_mode(reg_mode), .carry_in(carry_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .carry_out(carry_out), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // Returns {carry, result}, straight from the ARM shifter rules
    function automatic logic [W:0] model(input logic [W-1:0] d, input shift_type_t st,
                                         input logic [AW-1:0] a, input logic rm, input logic ci);
        int n;
        int m;
        logic [W-1:0] r;
        n = rm ? int'(a) : int'(a[4:0]);
        if (!rm && n == 0) begin
            if (st == SH_ROR) return {d[0], ci, d[W-1:1]};
            if (st == SH_LSR || st == SH_ASR) n = W;
        end
        if (n == 0) return {ci, d};
        case (st)
            SH_LSL: begin
                if (n < W)  return {d[W-n], d << n};
                if (n == W) return {d[0], {W{1'b0}}};
                return '0;
            end
            SH_LSR: begin
                if (n < W)  return {d[n-1], d >> n};
                if (n == W) return {d[W-1], {W{1'b0}}};
                return '0;
            end
            SH_ASR: begin
                if (n < W) begin
                    r = W'($signed(d) >>> n);
                    return {d[n-1], r};
                end
                return {d[W-1], {W{d[W-1]}}};
            end
            default: begin
                m = n % W;
                if (m == 0) return {d[W-1], d};
                r = (d >> m) | (d << (W - m));
                return {d[m-1], r};
            end
        endcase
    endfunction

    // Scoreboard and stall-stability monitor
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_d;
    logic          prev_c;
    logic [TW-1:0] prev_tg;

    always @(negedge clk) begin
        exp_t       e;
        logic [W:0] mr;
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", data_out, prev_d);
                chk("stall_carry", carry_out, prev_c);
                chk("stall_tag", tag_out, prev_tg);
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_d     = data_out;
            prev_c     = carry_out;
            prev_tg    = tag_out;
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    chk("sb_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("sb_data", data_out, e.d);
                        chk("sb_carry", carry_out, e.c);
                        chk("sb_tag", tag_out, e.tg);
                    end
                end
                if (in_valid && in_ready) begin
                    mr   = model(data_in, shift_type, shift_amount, reg_mode, carry_in);
                    e.d  = mr[W-1:0];
                    e.c  = mr[W];
                    e.tg = tag_in;
                    q.push_back(e);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic set_op(input logic [W-1:0] d, input shift_type_t st, input logic [AW-1:0] a,
                          input logic rm, input logic ci, input logic [TW-1:0] tg);
        data_in = d; shift_type = st; shift_amount = a;
        reg_mode = rm; carry_in = ci; tag_in = tg;
    endtask

    // Entered and left at posedge+1
    task automatic issue(input logic [W-1:0] d, input shift_type_t st, input logic [AW-1:0] a,
                         input logic rm, input logic ci, input logic [TW-1:0] tg);
        int k;
        k = 0;
        set_op(d, st, a, rm, ci, tg);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("accept_timeout", k, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_dir(input string nm, input logic [W-1:0] d, input shift_type_t st,
                          input logic [AW-1:0] a, input logic rm, input logic ci,
                          input logic [TW-1:0] tg, input logic [W-1:0] ed, input logic ec);
        int lat;
        issue(d, st, a, rm, ci, tg);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, lat, ST);
        chk({nm, "_data"}, data_out, ed);
        chk({nm, "_carry"}, carry_out, ec);
        chk({nm, "_tag"}, tag_out, tg);
        @(posedge clk); #1;
    endtask

    function automatic logic [AW-1:0] rand_amt();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd32;
            2:       return AW'($urandom_range(33, 63));
            3:       return 8'd64;
            4:       return AW'($urandom_range(1, 31));
            default: return AW'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        bit pat [4];
        int i;
        int k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op('0, SH_LSL, '0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data_out", data_out, '0);
        chk("rst_carry_out", carry_out, 1'b0);
        chk("rst_tag_out", tag_out, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Boundary encodings
        do_dir("reg_lsr32",   32'h8000_0001, SH_LSR, 8'd32, 1'b1, 1'b0, 4'h1, 32'h0000_0000, 1'b1);
        do_dir("reg_lsr33",   32'h8000_0001, SH_LSR, 8'd33, 1'b1, 1'b0, 4'h2, 32'h0000_0000, 1'b0);
        do_dir("imm_rrx",     32'h0000_0003, SH_ROR, 8'd0,  1'b0, 1'b1, 4'h3, 32'h8000_0001, 1'b1);
        do_dir("imm_asr0",    32'h8000_0000, SH_ASR, 8'd0,  1'b0, 1'b0, 4'h4, 32'hFFFF_FFFF, 1'b1);
        do_dir("reg_ror64",   32'h8000_0000, SH_ROR, 8'd64, 1'b1, 1'b0, 4'h5, 32'h8000_0000, 1'b1);
        do_dir("reg_lsl0",    32'h1234_5678, SH_LSL, 8'd0,  1'b1, 1'b1, 4'h6, 32'h1234_5678, 1'b1);
        do_dir("reg_lsl32",   32'h0000_0001, SH_LSL, 8'd32, 1'b1, 1'b0, 4'h7, 32'h0000_0000, 1'b1);
        do_dir("reg_lsl33",   32'hFFFF_FFFF, SH_LSL, 8'd33, 1'b1, 1'b1, 4'h8, 32'h0000_0000, 1'b0);
        do_dir("imm_lsr0",    32'h8000_0000, SH_LSR, 8'd0,  1'b0, 1'b0, 4'h9, 32'h0000_0000, 1'b1);
        do_dir("imm_lsl4",    32'hF000_000F, SH_LSL, 8'd4,  1'b0, 1'b0, 4'hA, 32'h0000_00F0, 1'b1);
        do_dir("imm_lsr_hi",  32'h0000_0100, SH_LSR, 8'h24, 1'b0, 1'b1, 4'hB, 32'h0000_0010, 1'b0);
        do_dir("reg_asr200",  32'h7000_0000, SH_ASR, 8'd200,1'b1, 1'b1, 4'hC, 32'h0000_0000, 1'b0);
        do_dir("reg_ror8",    32'h0000_0180, SH_ROR, 8'd8,  1'b1, 1'b0, 4'hD, 32'h8000_0001, 1'b1);

        // Back-to-back stream with a stalling consumer
        i = 0;
        k = 0;
        while ((i < 8 || q.size() != 0) && k < 200) begin
            out_ready = pat[k % 4];
            if (i < 8) begin
                set_op($urandom, shift_type_t'($urandom_range(0, 3)), rand_amt(),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(i));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_accepted", i, 8);
        chk("stream_drained", q.size(), 0);

        // Flush with two in flight plus a new input
        set_op(32'h1111_1111, SH_LSL, 8'd1, 1'b0, 1'b0, 4'h1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_op(32'h2222_2222, SH_LSL, 8'd2, 1'b0, 1'b0, 4'h2);
        @(posedge clk); #1;
        set_op(32'h3333_3333, SH_LSL, 8'd3, 1'b0, 1'b0, 4'h3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("flush_out_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        do_dir("post_flush",  32'h0000_00FF, SH_ROR, 8'd4,  1'b0, 1'b0, 4'hE, 32'hF000_000F, 1'b1);

`ifdef ARM7TDMI_SHIFT_REGCYCLE_EN
        set_op(32'h0000_0010, SH_LSR, 8'd4, 1'b1, 1'b0, 4'h5);
        in_valid = 1'b1;
        @(negedge clk);
        chk("regcyc_first", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("regcyc_second", in_ready, 1'b1);
        @(posedge clk); #1;
        set_op(32'h0000_0010, SH_LSR, 8'd4, 1'b0, 1'b0, 4'h6);
        @(negedge clk);
        chk("imm_first", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (ST + 2) @(posedge clk);
        #1;
        chk("regcyc_drained", q.size(), 0);
`endif

        // Random traffic with occasional flush
        for (int r = 0; r < 400; r++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            set_op($urandom, shift_type_t'($urandom_range(0, 3)), rand_amt(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 4) @(posedge clk);
        #1;
        chk("random_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
